// File: rtl/tile2048_pkg.sv
// Shared types and helpers for the 2048 tile engine.
// Boards are stored as 4-bit exponents; 0 marks an empty cell.
package tile2048_pkg;

  typedef logic [3:0] exp_t;
  typedef exp_t [3:0] line_t;

  typedef enum logic [2:0] {IDLE, SLIDE, SPAWN, CHECK, DONE} state_t;
  typedef enum logic [1:0] {LEFT, RIGHT, UP, DOWN} dir_t;

  localparam logic [15:0] LFSR_RESEED = 16'hACE1;

  // Fibonacci LFSR, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/line_merge.sv
// Combinational 2048 line merge toward index 0: compact empties, then merge
// each equal adjacent pair once while scanning from index 0.
module line_merge
  import tile2048_pkg::*;
#(
  parameter int WIN_EXP = 11
) (
  input  line_t       line_in,
  output line_t       line_out,
  output logic        changed,
  output logic [12:0] score_add,
  output logic        hit_win
);

  // One spare zero slot so the pair compare at index 3 never matches.
  exp_t        comp [5];
  exp_t        m;
  logic [2:0]  k;
  logic        skip;
  logic [16:0] acc;

  always_comb begin
    comp     = '{default: '0};
    line_out = '0;
    hit_win  = 1'b0;
    skip     = 1'b0;
    acc      = '0;
    m        = '0;
    k        = '0;
    for (int i = 0; i < 4; i++)
      if (line_in[i] != '0) begin
        comp[k] = line_in[i];
        k       = k + 3'd1;
      end
    k = '0;
    for (int i = 0; i < 4; i++) begin
      if (skip) skip = 1'b0;
      else if (comp[i] != '0) begin
        if (comp[i] == comp[i+1]) begin
          m       = (comp[i] == 4'hF) ? 4'hF : comp[i] + 4'd1;
          acc     = acc + (17'd1 << m);
          hit_win = hit_win | (32'(m) >= WIN_EXP);
          skip    = 1'b1;
          line_out[k[1:0]] = m;
        end else begin
          line_out[k[1:0]] = comp[i];
        end
        k = k + 3'd1;
      end
    end
  end

  assign changed   = (line_out != line_in);
  // Two very high merges in one line can exceed the 13-bit port; clamp it.
  assign score_add = (acc > 17'h1FFF) ? 13'h1FFF : acc[12:0];

endmodule

// File: rtl/tile_engine_2048.sv
// 2048 game engine: holds the exponent board, runs slide/merge moves one line
// per cycle, spawns tiles from an LFSR and exposes a double-buffered display.
module tile_engine_2048
  import tile2048_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          WIN_EXP   = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   new_game,
  input  logic                   move_valid,
  input  logic [1:0]             move_dir,
  input  logic                   load_valid,
  input  logic [3:0][3:0][3:0]   load_board,
  output logic [3:0][3:0][11:0]  board_o,
  output logic [19:0]            score_o,
  output logic                   busy,
  output logic                   done,
  output logic                   win,
  output logic                   lost
);

  localparam logic [15:0] SEED0 = (LFSR_SEED == 16'h0) ? LFSR_RESEED : LFSR_SEED;

  exp_t [3:0][3:0] brd;
  state_t          state;
  dir_t            dir;
  logic [15:0]     lfsr, lfsr_nxt;
  logic [1:0]      ln;
  logic            changed;
  logic [1:0]      spawn_cnt;
  logic [3:0]      idx;
  logic [3:0]      probes;
  line_t           lin, lout;
  logic            l_changed, l_win;
  logic [12:0]     l_score;
  logic [20:0]     score_sum;
  logic            any_empty, any_pair;

  assign lfsr_nxt  = lfsr_step(lfsr);
  assign busy      = (state == SLIDE) || (state == SPAWN) || (state == CHECK);
  assign score_sum = {1'b0, score_o} + {8'd0, l_score};

  // Orient the current line so the merge always runs toward index 0.
  always_comb begin
    lin = '0;
    for (int i = 0; i < 4; i++)
      case (dir)
        LEFT:  lin[i] = brd[ln][i];
        RIGHT: lin[i] = brd[ln][3-i];
        UP:    lin[i] = brd[i][ln];
        DOWN:  lin[i] = brd[3-i][ln];
      endcase
  end

  line_merge #(.WIN_EXP(WIN_EXP)) u_merge (
    .line_in   (lin),
    .line_out  (lout),
    .changed   (l_changed),
    .score_add (l_score),
    .hit_win   (l_win)
  );

  always_comb begin
    any_empty = 1'b0;
    any_pair  = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (brd[r][c] == '0) any_empty = 1'b1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (brd[r][c] == brd[r][c+1]) any_pair = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        if (brd[r][c] == brd[r+1][c]) any_pair = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      brd       <= '0;
      board_o   <= '0;
      score_o   <= '0;
      win       <= 1'b0;
      lost      <= 1'b0;
      done      <= 1'b0;
      state     <= IDLE;
      dir       <= LEFT;
      lfsr      <= SEED0;
      ln        <= '0;
      changed   <= 1'b0;
      spawn_cnt <= '0;
      idx       <= '0;
      probes    <= '0;
    end else begin
      lfsr <= lfsr_nxt;
      done <= 1'b0;
      if (new_game) begin
        // Accepted in every state; any half-finished operation is dropped.
        brd       <= '0;
        score_o   <= '0;
        win       <= 1'b0;
        lost      <= 1'b0;
        spawn_cnt <= 2'd2;
        idx       <= lfsr_nxt[3:0];
        probes    <= '0;
        state     <= SPAWN;
      end else begin
        case (state)
          IDLE: begin
            if (load_valid) begin
              brd   <= load_board;
              state <= DONE;
            end else if (move_valid && !win && !lost) begin
              dir     <= dir_t'(move_dir);
              ln      <= '0;
              changed <= 1'b0;
              state   <= SLIDE;
            end
          end
          SLIDE: begin
            for (int i = 0; i < 4; i++)
              case (dir)
                LEFT:  brd[ln][i]   <= lout[i];
                RIGHT: brd[ln][3-i] <= lout[i];
                UP:    brd[i][ln]   <= lout[i];
                DOWN:  brd[3-i][ln] <= lout[i];
              endcase
            score_o <= score_sum[20] ? 20'hFFFFF : score_sum[19:0];
            if (l_win) win <= 1'b1;
            ln      <= ln + 2'd1;
            changed <= changed | l_changed;
            if (ln == 2'd3) begin
              if (changed || l_changed) begin
                spawn_cnt <= 2'd1;
                idx       <= lfsr_nxt[3:0];
                probes    <= '0;
                state     <= SPAWN;
              end else begin
                state <= CHECK;
              end
            end
          end
          SPAWN: begin
            if (spawn_cnt == '0) begin
              state <= CHECK;
            end else if (brd[idx[3:2]][idx[1:0]] == '0) begin
              brd[idx[3:2]][idx[1:0]] <= (lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;
              spawn_cnt <= spawn_cnt - 2'd1;
              idx       <= lfsr_nxt[3:0];
              probes    <= '0;
              if (spawn_cnt == 2'd1) state <= CHECK;
            end else begin
              idx    <= idx + 4'd1;
              probes <= probes + 4'd1;
              if (probes == 4'd15) state <= CHECK;
            end
          end
          CHECK: begin
            if (!any_empty && !any_pair) lost <= 1'b1;
            state <= DONE;
          end
          DONE: begin
            for (int r = 0; r < 4; r++)
              for (int c = 0; c < 4; c++)
                board_o[r][c] <= (brd[r][c] == '0) ? 12'd0 : 12'(32'd1 << brd[r][c]);
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
